// File: rtl/rgals_clk_pkg.sv
// rtl/rgals_clk_pkg.sv - shared state encoding, widths and select encodings for the rGALS clock switch controller
package rgals_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_SETTLE  = 2'd3
    } ctrl_state_e;

    localparam int SETTLE_CNT_W = 8;
    localparam int SWITCH_CNT_W = 16;

    localparam logic CLK_SEL_CLK1 = 1'b0;
    localparam logic CLK_SEL_CLK2 = 1'b1;

    function automatic logic [SWITCH_CNT_W-1:0] sat_inc(input logic [SWITCH_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rgals_rr_arb.sv
// rtl/rgals_rr_arb.sv - combinational round-robin arbiter; priority starts at ptr and wraps to index 0
module rgals_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;

    // Requests at or above ptr win; fall back to the whole vector when none are pending there.
    always_comb begin
        hi_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
        hi_req  = req & hi_mask;
        pick    = (|hi_req) ? hi_req : req;
        gnt     = pick & (~pick + NREQ'(1));
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rgals_clk_switch_ctrl.sv
// rtl/rgals_clk_switch_ctrl.sv - rGALS clock-select sequencer; RGALS_CLK_SWITCH_CTRL_QUIESCE_EN adds the datapath quiesce handshake
module rgals_clk_switch_ctrl
    import rgals_clk_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk_out,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_val,
    output logic [NREQ-1:0]         req_rdy,
    input  logic [NREQ-1:0]         req_msg,
    output logic                    switch_val,
    input  logic                    switch_rdy,
    output logic                    switch_msg,
    output logic                    quiesce_req,
    input  logic                    quiesce_ack,
    output logic                    cur_sel,
    output logic                    busy,
    output logic [SWITCH_CNT_W-1:0] switch_count
);

    localparam int IDX_W = $clog2(NREQ);

    ctrl_state_e              state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         offer_idx_q, offer_idx_d;
    logic                     tgt_q, tgt_d;
    logic                     cur_sel_q, cur_sel_d;
    logic [SETTLE_CNT_W-1:0]  settle_q, settle_d;
    logic [SWITCH_CNT_W-1:0]  count_q, count_d;
    logic [NREQ-1:0]          req_rdy_q, req_rdy_d;
    logic                     switch_val_q, switch_val_d;
    logic                     switch_msg_q, switch_msg_d;
    logic                     quiesce_req_q, quiesce_req_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic [NREQ-1:0]          arb_gnt;
    logic [IDX_W-1:0]         arb_gnt_idx;

    // The offer for the next cycle is arbitrated from this cycle's requests, keeping req_val off every output path.
    rgals_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_val),
        .ptr     (ptr_d),
        .gnt     (arb_gnt),
        .gnt_idx (arb_gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tgt_d     = tgt_q;
        cur_sel_d = cur_sel_q;
        settle_d  = settle_q;
        count_d   = count_q;
        accept    = |(req_val & req_rdy_q);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d = (offer_idx_q == IDX_W'(NREQ - 1)) ? '0 : offer_idx_q + IDX_W'(1);
                    if (req_msg[offer_idx_q] != cur_sel_q) begin
                        tgt_d = req_msg[offer_idx_q] ? CLK_SEL_CLK2 : CLK_SEL_CLK1;
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
                        state_d = ST_QUIESCE;
`else
                        state_d = ST_ISSUE;
`endif
                    end
                end
            end
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
            ST_QUIESCE: begin
                if (quiesce_ack) begin
                    state_d = ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                if (switch_rdy) begin
                    cur_sel_d = tgt_q;
                    count_d   = sat_inc(count_q);
                    settle_d  = SETTLE_CNT_W'(SETTLE_CYCLES);
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q == SETTLE_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy_d    = (state_d == ST_IDLE) ? arb_gnt : '0;
        offer_idx_d  = arb_gnt_idx;
        switch_val_d = (state_d == ST_ISSUE);
        switch_msg_d = (state_d == ST_ISSUE) ? tgt_d : CLK_SEL_CLK1;
        busy_d       = (state_d != ST_IDLE);
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
        quiesce_req_d = (state_d != ST_IDLE);
`else
        quiesce_req_d = 1'b0;
`endif
    end

`ifndef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
    logic unused_quiesce_ack;
    assign unused_quiesce_ack = quiesce_ack;
`endif

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            offer_idx_q   <= '0;
            tgt_q         <= CLK_SEL_CLK1;
            cur_sel_q     <= CLK_SEL_CLK1;
            settle_q      <= '0;
            count_q       <= '0;
            req_rdy_q     <= '0;
            switch_val_q  <= 1'b0;
            switch_msg_q  <= 1'b0;
            quiesce_req_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            offer_idx_q   <= offer_idx_d;
            tgt_q         <= tgt_d;
            cur_sel_q     <= cur_sel_d;
            settle_q      <= settle_d;
            count_q       <= count_d;
            req_rdy_q     <= req_rdy_d;
            switch_val_q  <= switch_val_d;
            switch_msg_q  <= switch_msg_d;
            quiesce_req_q <= quiesce_req_d;
            busy_q        <= busy_d;
        end
    end

    assign req_rdy      = req_rdy_q;
    assign switch_val   = switch_val_q;
    assign switch_msg   = switch_msg_q;
    assign quiesce_req  = quiesce_req_q;
    assign cur_sel      = cur_sel_q;
    assign busy         = busy_q;
    assign switch_count = count_q;

endmodule

// File: tb/tb_rgals_clk_switch_ctrl.sv
// tb/tb_rgals_clk_switch_ctrl.sv - randomized scoreboard bench for rgals_clk_switch_ctrl
module tb_rgals_clk_switch_ctrl;

    localparam int NREQ   = 2;
    localparam int SETTLE = 4;

    logic            clk_out     = 1'b0;
    logic            reset       = 1'b1;
    logic [NREQ-1:0] req_val     = '0;
    logic [NREQ-1:0] req_msg     = '0;
    logic            switch_rdy  = 1'b0;
    logic            quiesce_ack = 1'b0;
    logic [NREQ-1:0] req_rdy;
    logic            switch_val;
    logic            switch_msg;
    logic            quiesce_req;
    logic            cur_sel;
    logic            busy;
    logic [15:0]     switch_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_sw  = 0;

    // Reference model: committed select, pointer, count, and the timestamps of the switch in flight.
    logic            m_sel = 1'b0;
    int              m_ptr = 0;
    int              m_cnt = 0;
    bit              active = 1'b0;
    bit              hs_done = 1'b0;
    int              t_acc = 0;
    int              v_hs = 0;
    logic            exp_q[$];
    logic [NREQ-1:0] acc_seen = '0;
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
    bit              ack_seen = 1'b0;
    int              u_ack = 0;
`endif

    rgals_clk_switch_ctrl #(
        .NREQ          (NREQ),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_out      (clk_out),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .switch_val   (switch_val),
        .switch_rdy   (switch_rdy),
        .switch_msg   (switch_msg),
        .quiesce_req  (quiesce_req),
        .quiesce_ack  (quiesce_ack),
        .cur_sel      (cur_sel),
        .busy         (busy),
        .switch_count (switch_count)
    );

    always #5 clk_out = ~clk_out;

    always @(posedge clk_out) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: compares every cycle against the model, then folds this cycle's handshakes into it.
    always @(negedge clk_out) begin
        logic [NREQ-1:0] acc;
        bit              exp_busy;
        bit              exp_sv;
        int              a;
        int              g;
        if (reset) begin
            chk("rst_req_rdy", 32'(req_rdy), 0);
            chk("rst_switch_val", 32'(switch_val), 0);
            chk("rst_switch_msg", 32'(switch_msg), 0);
            chk("rst_quiesce_req", 32'(quiesce_req), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_cur_sel", 32'(cur_sel), 0);
            chk("rst_count", 32'(switch_count), 0);
            m_sel    = 1'b0;
            m_ptr    = 0;
            m_cnt    = 0;
            active   = 1'b0;
            acc_seen = '0;
            exp_q.delete();
        end else begin
            if (active && hs_done && cyc > v_hs + SETTLE) active = 1'b0;
            exp_busy = active && cyc > t_acc && (!hs_done || cyc <= v_hs + SETTLE);
            exp_sv   = active && cyc > t_acc && !hs_done;
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
            exp_sv = exp_sv && ack_seen && cyc > u_ack;
            chk("quiesce_req", 32'(quiesce_req), 32'(exp_busy));
`else
            chk("quiesce_req", 32'(quiesce_req), 0);
`endif
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("switch_val", 32'(switch_val), 32'(exp_sv));
            chk("cur_sel", 32'(cur_sel), 32'(m_sel));
            chk("switch_count", 32'(switch_count), m_cnt);
            if (exp_busy) chk("req_rdy_busy", 32'(req_rdy), 0);
            else chk("req_rdy_onehot0", 32'($onehot0(req_rdy)), 1);
            if (exp_sv && exp_q.size() > 0) chk("switch_msg", 32'(switch_msg), 32'(exp_q[0]));

            acc      = req_val & req_rdy;
            acc_seen = acc;
            if (acc != '0) begin
                a = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (acc[i]) a = i;
                g = rr_pick(m_ptr, req_val);
                chk("grant_index", 32'(acc), 32'(NREQ'(1) << g));
                m_ptr = (a + 1) % NREQ;
                if (req_msg[a] != m_sel) begin
                    active  = 1'b1;
                    hs_done = 1'b0;
                    t_acc   = cyc;
                    exp_q.push_back(req_msg[a]);
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
                    ack_seen = 1'b0;
`endif
                end
            end
`ifdef RGALS_CLK_SWITCH_CTRL_QUIESCE_EN
            if (active && cyc > t_acc && !ack_seen && quiesce_ack) begin
                ack_seen = 1'b1;
                u_ack    = cyc;
            end
`endif
            if (switch_val && switch_rdy && active && !hs_done && exp_q.size() > 0) begin
                m_sel   = exp_q.pop_front();
                hs_done = 1'b1;
                v_hs    = cyc;
                if (m_cnt < 65535) m_cnt++;
                n_sw++;
            end
        end
    end

    // mode 0: random requests, 1: fixed alternating targets with ready held, 2: drain random, 3: drain ready held
    task automatic step(input int mode);
        bit any;
        @(posedge clk_out);
        #1;
        req_val = req_val & ~acc_seen;
        any     = |req_val;
        for (int i = 0; i < NREQ; i++) begin
            if (mode < 2 && !req_val[i] && (busy || !any) && (mode == 1 || $urandom_range(0, 3) == 0)) begin
                req_msg[i] = (mode == 1) ? logic'(i % 2 == 0) : logic'($urandom_range(0, 1));
                req_val[i] = 1'b1;
                any        = 1'b1;
            end
        end
        switch_rdy  = (mode == 1 || mode == 3) ? 1'b1 : logic'($urandom_range(0, 2) != 0);
        quiesce_ack = (mode == 3) ? 1'b1 : logic'($urandom_range(0, 4) == 0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk_out);
        #1;
        reset = 1'b0;
        repeat (3) step(2);

        req_msg[0] = 1'b1;
        req_val[0] = 1'b1;
        repeat (12) step(3);
        chk("first_switch_count", 32'(switch_count), 1);
        chk("first_switch_sel", 32'(cur_sel), 1);

        repeat (80) step(1);
        repeat (600) step(0);

        for (int k = 0; k < 300 && (busy || req_val != '0); k++) step(2);
        req_msg[0]  = ~m_sel;
        req_val     = NREQ'(1);
        switch_rdy  = 1'b0;
        quiesce_ack = 1'b1;
        seen        = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk_out);
            #1;
            req_val = req_val & ~acc_seen;
            seen    = switch_val;
        end
        chk("issue_reached", 32'(seen), 1);
        reset   = 1'b1;
        req_val = '0;
        repeat (2) @(posedge clk_out);
        #1;
        reset      = 1'b0;
        req_msg[0] = 1'b1;
        req_val[0] = 1'b1;
        repeat (15) step(3);
        chk("post_reset_count", 32'(switch_count), 1);
        chk("post_reset_sel", 32'(cur_sel), 1);

        for (int k = 0; k < 300 && (busy || req_val != '0); k++) step(2);
        chk("drained", {30'd0, busy, |req_val}, 0);
        chk("switches_seen", 32'(n_sw > 20), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
